seg_scroll_ctrl: RTL and testbench
==================================

SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter MSG_LEN, default 16: number of BCD digits in the message.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is lit.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: clk cycles a button must be stable.
REQ-005 SHALL have parameter STEP_TICKS, default 10000000: scroll period unit in clk cycles.
REQ-006 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-007 SHALL have port cpu_resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port msg  input  4*MSG_LEN  BCD message; digit 0 is the most significant nibble.
REQ-009 SHALL have port btn_faster, btn_slower, btn_pause, btn_dir, btn_step  input  1 each  raw push-buttons, active-high.
REQ-010 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port an  output  NUM_DIGITS  anodes, active-low; an[NUM_DIGITS-1] is the leftmost digit.
REQ-012 SHALL have port paused  output  1  high while scrolling is halted.
REQ-013 SHALL have port speed  output  3  current speed index (0 slowest, 7 fastest).

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser and a debouncer, which emits a one-cycle pulse when the stable level rises after DEBOUNCE_CYCLES consecutive identical samples.
REQ-015 The virtual tape SHALL be NUM_DIGITS blanks followed by MSG_LEN message digits, length L = NUM_DIGITS+MSG_LEN.
REQ-016 Position pos SHALL range 0..L-1, and display digit k (0 = leftmost) SHALL show tape[(pos+k) mod L].
REQ-017 The tick counter SHALL count to STEP_TICKS*(8-speed)-1, emit a tick, and restart from 0; it SHALL also clear on any speed change.
REQ-018 On a tick with paused=0: dir=left SHALL increment pos mod L (L-1 -> 0), and dir=right SHALL decrement pos mod L (0 -> L-1).
REQ-019 A faster pulse SHALL increment speed, saturating at 7; a slower pulse SHALL decrement it, saturating at 0; both in the same cycle SHALL leave speed unchanged.
REQ-020 A pause pulse SHALL toggle paused, and a tick in the same cycle SHALL NOT advance pos.
REQ-021 A dir pulse SHALL toggle the direction, effective from the next tick.
REQ-022 A step pulse while paused=1 SHALL move pos one place in the current direction; while paused=0 it SHALL be ignored.
REQ-023 The scan index SHALL advance every REFRESH_DIV cycles, from leftmost to rightmost, wrapping.
REQ-024 an SHALL be one-hot-low at the scan index, and seg SHALL be the decoded digit, both registered in the same cycle (1-cycle latency from scan/pos change).
REQ-025 Decode SHALL map 0..9 to the standard active-low patterns (0=1000000, 1=1111001, 8=0000000); tape blanks and nibbles 10..15 SHALL give seg=1111111.
REQ-026 msg SHALL be read live with no capture; a change SHALL appear on the next digit refresh.

Reset
REQ-027 While cpu_resetn=0, outputs SHALL be: seg=1111111, an=all ones, paused=0, speed=3.
REQ-028 While cpu_resetn=0, internal state SHALL be: pos=0, dir=left, scan index=0, all counters 0, debouncer stable levels 0.
REQ-029 Reset mid-scroll SHALL abandon pending pulses, and after release the first tick SHALL occur STEP_TICKS*5 cycles later.

Structure
REQ-030 The seven-segment pattern constants and the speed width SHALL live in a shared package, seg_pkg.
REQ-031 Debouncing SHALL be one sub-module, btn_debounce, instantiated once per button.

Verification (NUM_DIGITS=4, MSG_LEN=4, REFRESH_DIV=4, DEBOUNCE_CYCLES=8, STEP_TICKS=10)
REQ-032 Reset release, msg=16'h1234 -> pos=0, all digits blank; first tick at cycle 50; at pos=4 the digits show 1,2,3,4 left to right.
REQ-033 Left scroll across wrap: pos=7 -> next tick gives pos=0; right scroll from pos=0 -> pos=7.
REQ-034 Five faster pulses from speed 3 -> speed=7, tick period 10; eight slower pulses -> speed=0, period 80; simultaneous pulses -> unchanged.
REQ-035 5-cycle button glitch -> no pulse; 20-cycle press -> exactly one pulse.
REQ-036 Pause, then three steps with dir=left from pos=2 -> pos=5, and no tick advance while paused.
REQ-037 nibble 4'hB in msg -> that digit shows seg=1111111 with its anode active.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, types and digit decoder for the scrolling display
package seg_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
    localparam logic [SPEED_W-1:0] SPEED_RST = 3'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// rtl/seg_scroll_ctrl_if.sv - bundle of the five push-button signals (raw or debounced pulses)
interface seg_scroll_ctrl_if;

    logic faster;
    logic slower;
    logic pause;
    logic dir;
    logic step;

    modport master (output faster, slower, pause, dir, step);
    modport slave  (input  faster, slower, pause, dir, step);

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser plus debouncer emitting a one-cycle rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settle;

    // cnt_q tracks how many consecutive samples have disagreed with the stable level.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        settle   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
        cnt_d    = ((sync2_q == stable_q) || settle) ? '0 : cnt_q + 1'b1;
        stable_d = settle ? sync2_q : stable_q;
        pulse_d  = settle && sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/seg_scroll_ctrl_btns.sv
// rtl/seg_scroll_ctrl_btns.sv - debouncer bank turning the raw buttons into command pulses
module seg_scroll_ctrl_btns #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_faster,
    input  logic btn_slower,
    input  logic btn_pause,
    input  logic btn_dir,
    input  logic btn_step,
    seg_scroll_ctrl_if.master evt
);

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_faster), .pulse(evt.faster)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_slower), .pulse(evt.slower)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_pause), .pulse(evt.pause)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_dir), .pulse(evt.dir)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_step), .pulse(evt.step)
    );

endmodule

// File: rtl/seg_scroll_ctrl.sv
// rtl/seg_scroll_ctrl.sv - scrolling BCD message on a multiplexed 7-segment display
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int MSG_LEN         = 16,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_TICKS      = 10000000
) (
    input  logic                   clk,
    input  logic                   cpu_resetn,
    input  logic [4*MSG_LEN-1:0]   msg,
    input  logic                   btn_faster,
    input  logic                   btn_slower,
    input  logic                   btn_pause,
    input  logic                   btn_dir,
    input  logic                   btn_step,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  an,
    output logic                   paused,
    output logic [SPEED_W-1:0]     speed
);

    localparam int TAPE_LEN = NUM_DIGITS + MSG_LEN;
    localparam int POS_W    = $clog2(TAPE_LEN);
    localparam int SCAN_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TICK_W   = $clog2(STEP_TICKS * 8);

    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(TAPE_LEN - 1);
    localparam logic [POS_W:0]    TAPE_LEN_W = (POS_W+1)'(TAPE_LEN);
    localparam logic [POS_W:0]    BLANKS_W   = (POS_W+1)'(NUM_DIGITS);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REFRESH_DIV - 1);

    seg_scroll_ctrl_if evt ();

    seg_scroll_ctrl_btns #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btns (
        .clk        (clk),
        .rst_n      (cpu_resetn),
        .btn_faster (btn_faster),
        .btn_slower (btn_slower),
        .btn_pause  (btn_pause),
        .btn_dir    (btn_dir),
        .btn_step   (btn_step),
        .evt        (evt)
    );

    logic [SPEED_W-1:0]    speed_q, speed_d;
    logic                  paused_q, paused_d;
    dir_e                  dir_q, dir_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [REF_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [SCAN_W-1:0]     scan_idx_q, scan_idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [TICK_W-1:0]     tick_lim;
    logic                  tick;
    logic                  advance;
    logic                  scan_wrap;
    logic [POS_W:0]        tape_sum;
    logic [POS_W:0]        tape_idx;
    int                    msg_idx;

    // Scroll control: a pause pulse wins over a coincident tick; steps only act while halted.
    always_comb begin
        speed_d = speed_q;
        if (evt.faster && !evt.slower && speed_q != SPEED_MAX) begin
            speed_d = speed_q + 1'b1;
        end else if (evt.slower && !evt.faster && speed_q != '0) begin
            speed_d = speed_q - 1'b1;
        end

        tick_lim   = TICK_W'(STEP_TICKS * (8 - int'(speed_q)) - 1);
        tick       = (tick_cnt_q == tick_lim);
        tick_cnt_d = (tick || speed_d != speed_q) ? '0 : tick_cnt_q + 1'b1;

        paused_d = paused_q ^ evt.pause;
        dir_d    = evt.dir ? dir_e'(~dir_q) : dir_q;
        advance  = paused_q ? evt.step : (tick && !evt.pause);

        pos_d = pos_q;
        if (advance) begin
            if (dir_q == DIR_LEFT) begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            end else begin
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
            end
        end
    end

    // Display scan: the tape is NUM_DIGITS blanks followed by the live message.
    always_comb begin
        scan_wrap  = (scan_cnt_q == REF_LAST);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_wrap) begin
            scan_idx_d = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + 1'b1;
        end

        tape_sum = {1'b0, pos_q} + (POS_W+1)'(scan_idx_q);
        tape_idx = (tape_sum >= TAPE_LEN_W) ? tape_sum - TAPE_LEN_W : tape_sum;
        msg_idx  = int'(tape_idx) - NUM_DIGITS;

        seg_d = SEG_BLANK;
        if (tape_idx >= BLANKS_W) begin
            seg_d = seg_decode(msg[4*(MSG_LEN-1-msg_idx) +: 4]);
        end
        an_d = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(scan_idx_q)));
    end

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            speed_q    <= SPEED_RST;
            paused_q   <= 1'b0;
            dir_q      <= DIR_LEFT;
            pos_q      <= '0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            speed_q    <= speed_d;
            paused_q   <= paused_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign paused = paused_q;
    assign speed  = speed_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// tb/tb_seg_scroll_ctrl.sv - self-checking bench for seg_scroll_ctrl
module tb_seg_scroll_ctrl;

    localparam int ND = 4;
    localparam int MS = 4;
    localparam int L  = ND + MS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] msg = 16'h1234;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        paused;
    logic [2:0]  speed;

    int checks = 0;
    int errors = 0;

    seg_scroll_ctrl_if btn_raw ();

    seg_scroll_ctrl #(
        .NUM_DIGITS(ND), .MSG_LEN(MS), .REFRESH_DIV(4),
        .DEBOUNCE_CYCLES(8), .STEP_TICKS(10)
    ) dut (
        .clk        (clk),
        .cpu_resetn (rst_n),
        .msg        (msg),
        .btn_faster (btn_raw.faster),
        .btn_slower (btn_raw.slower),
        .btn_pause  (btn_raw.pause),
        .btn_dir    (btn_raw.dir),
        .btn_step   (btn_raw.step),
        .seg        (seg),
        .an         (an),
        .paused     (paused),
        .speed      (speed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0] mask;   // {step, dir, pause, slower, faster}
        int         exp_speed;
        int         exp_paused;
        int         exp_period;  // 0 = do not measure
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_btns(input logic [4:0] mask);
        btn_raw.faster = mask[0];
        btn_raw.slower = mask[1];
        btn_raw.pause  = mask[2];
        btn_raw.dir    = mask[3];
        btn_raw.step   = mask[4];
    endtask

    task automatic press(input logic [4:0] mask);
        set_btns(mask);
        repeat (20) @(negedge clk);
        set_btns(5'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic glitch(input logic [4:0] mask);
        set_btns(mask);
        repeat (5) @(negedge clk);
        set_btns(5'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_btns(5'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pos_change(input int limit, output int cycles, output int ok);
        int p0;
        p0 = int'(dut.pos_q);
        cycles = 0;
        ok = 0;
        while (cycles < limit && ok == 0) begin
            @(negedge clk);
            cycles++;
            if (int'(dut.pos_q) != p0) ok = 1;
        end
    endtask

    function automatic logic [6:0] ref_pattern(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int p, input int k, input logic [15:0] m);
        int t;
        t = (p + k) % L;
        if (t < ND) return 7'h7F;
        return ref_pattern(int'((m >> (4 * (MS - 1 - (t - ND)))) & 16'hF));
    endfunction

    initial begin
        int c;
        int ok;
        int m;
        int k;

        vecs[0]  = '{5'b00001, 4, 0, 0};
        vecs[1]  = '{5'b00001, 5, 0, 0};
        vecs[2]  = '{5'b00001, 6, 0, 0};
        vecs[3]  = '{5'b00001, 7, 0, 0};
        vecs[4]  = '{5'b00001, 7, 0, 10};
        vecs[5]  = '{5'b00011, 7, 0, 0};
        vecs[6]  = '{5'b00010, 6, 0, 0};
        vecs[7]  = '{5'b00010, 5, 0, 0};
        vecs[8]  = '{5'b00010, 4, 0, 0};
        vecs[9]  = '{5'b00010, 3, 0, 0};
        vecs[10] = '{5'b00010, 2, 0, 0};
        vecs[11] = '{5'b00010, 1, 0, 0};
        vecs[12] = '{5'b00010, 0, 0, 0};
        vecs[13] = '{5'b00010, 0, 0, 80};
        vecs[14] = '{5'b00011, 0, 0, 0};
        vecs[15] = '{5'b00100, 0, 1, 0};
        vecs[16] = '{5'b00100, 0, 0, 0};
        vecs[17] = '{5'b00001, 1, 0, 70};

        set_btns(5'b0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_paused", paused, 0);
        chk("rst_speed", speed, 3);
        chk("rst_pos", dut.pos_q, 0);
        rst_n = 1'b1;

        // Free-running scroll against a time-based model, live and random message contents.
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            m = n - 1;
            k = (m / 4) % ND;
            chk("run_pos", dut.pos_q, (n / 50) % L);
            chk("run_seg", seg, ref_seg((m / 50) % L, k, msg));
            chk("run_an", an, 15 & ~(1 << (ND - 1 - k)));
            if (n == 220) msg = 16'h1B34;
            else if (n >= 260 && n % 7 == 0) msg = 16'($urandom);
        end

        // A half-debounced press is abandoned by reset; then right scroll wraps 0 -> 7.
        set_btns(5'b00001);
        repeat (8) @(negedge clk);
        do_reset();
        press(5'b01000);
        wait_pos_change(100, c, ok);
        chk("right_tick_ok", ok, 1);
        chk("first_tick_after_reset", c, 10);
        chk("right_wrap_pos", dut.pos_q, 7);
        chk("abandoned_pulse_speed", speed, 3);
        wait_pos_change(100, c, ok);
        chk("right_next_pos", dut.pos_q, 6);

        // Button table: speed saturation, simultaneous presses, pause toggle, tick periods.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].mask);
            chk($sformatf("vec%0d_speed", i), speed, vecs[i].exp_speed);
            chk($sformatf("vec%0d_paused", i), paused, vecs[i].exp_paused);
            if (vecs[i].exp_period != 0) begin
                wait_pos_change(200, c, ok);
                wait_pos_change(200, c, ok);
                chk($sformatf("vec%0d_period_ok", i), ok, 1);
                chk($sformatf("vec%0d_period", i), c, vecs[i].exp_period);
            end
        end

        // Pause at pos 2, three steps left, glitches ignored, ticks frozen.
        do_reset();
        wait_pos_change(100, c, ok);
        chk("pause_first_tick", c, 50);
        wait_pos_change(100, c, ok);
        chk("pause_reach_pos2", dut.pos_q, 2);
        press(5'b00100);
        chk("pause_on", paused, 1);
        chk("pause_pos_held", dut.pos_q, 2);
        for (int i = 0; i < 3; i++) press(5'b10000);
        chk("step_pos", dut.pos_q, 5);
        glitch(5'b10000);
        chk("step_glitch_pos", dut.pos_q, 5);
        glitch(5'b00001);
        chk("faster_glitch_speed", speed, 3);
        repeat (200) @(negedge clk);
        chk("paused_no_tick_pos", dut.pos_q, 5);
        chk("paused_still", paused, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
